// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver and two-byte command parser with a valid/ready holding register.
// Defining UART_CMD_TIMEOUT_EN adds an inter-byte timeout and the timeout_err output.
module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [4:0]  HDR_TAG      = 5'b10100,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       rx,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [3:0] cmd_a,
  output logic [3:0] cmd_b,
  output logic [2:0] cmd_opcode,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       hdr_err,
`ifdef UART_CMD_TIMEOUT_EN
  output logic       timeout_err,
`endif
  output logic       overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} rx_state_t;
  typedef enum logic {P_HDR = 1'b0, P_DATA = 1'b1} p_state_t;

  logic             rx_m;
  logic             rx_s;
  logic             rx_prev;
  logic [2:0]       warm;
  logic             start_edge;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             byte_done;
  p_state_t         pstate;
  logic [2:0]       pend_op;
  logic             cmd_done;
  logic             tmo_fire;

  // warm only fills once rx_prev holds a real post-reset sample, so a line
  // that is already low out of reset never looks like a falling edge
  assign start_edge = warm[2] & rx_prev & ~rx_s;
  assign cmd_done   = byte_done & (pstate == P_DATA);

  // two-flop synchronizer, previous-sample flop and post-reset warm-up
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      warm    <= 3'b000;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
      warm    <= {warm[1:0], 1'b1};
    end
  end

  // byte receiver: mid-bit sampling, LSB first, stop-bit check
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      if (!ena) begin
        state   <= IDLE;
        cnt     <= '0;
        rx_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) begin
              state   <= START;
              cnt     <= '0;
              rx_busy <= 1'b1;
            end
          end
          START: begin
            if (cnt == HALF_M1) begin
              cnt <= '0;
              if (rx_s) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state   <= DATA;
                bit_idx <= 3'd0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == FULL_M1) begin
              cnt     <= '0;
              shreg   <= {rx_s, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (cnt == FULL_M1) begin
              cnt     <= '0;
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (rx_s) begin
                byte_done <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            cnt     <= '0;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // header/operand parser and the one-entry command holding register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pstate     <= P_HDR;
      pend_op    <= 3'd0;
      hdr_err    <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_a      <= 4'd0;
      cmd_b      <= 4'd0;
      cmd_opcode <= 3'd0;
      overflow   <= 1'b0;
    end else begin
      hdr_err <= 1'b0;
      case (pstate)
        P_HDR: begin
          if (byte_done) begin
            if (shreg[7:3] == HDR_TAG) begin
              pend_op <= shreg[2:0];
              pstate  <= P_DATA;
            end else begin
              hdr_err <= 1'b1;
            end
          end
        end
        P_DATA: begin
          if (byte_done || frame_err || tmo_fire) begin
            pstate <= P_HDR;
          end
        end
        default: pstate <= P_HDR;
      endcase

      if (cmd_done) begin
        if (!cmd_valid || cmd_ready) begin
          cmd_valid  <= 1'b1;
          cmd_opcode <= pend_op;
          cmd_a      <= shreg[7:4];
          cmd_b      <= shreg[3:0];
        end else begin
          overflow <= 1'b1;
        end
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W = $clog2(TMO_LIMIT + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // a byte event or a new start in the same cycle wins over the timeout
  assign tmo_fire = (pstate == P_DATA) && !rx_busy && !start_edge && !byte_done &&
                    !frame_err && (tmo_cnt == TMO_W'(TMO_LIMIT - 1));

  // idle-time counter, only meaningful while an operand byte is awaited
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (start_edge || pstate != P_DATA) begin
        tmo_cnt <= '0;
      end else if (tmo_fire) begin
        tmo_cnt     <= '0;
        timeout_err <= 1'b1;
      end else if (!rx_busy) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`else
  // without the timeout the parser waits for the operand indefinitely
  assign tmo_fire = 1'b0 & (TIMEOUT_BITS == 32'd0);
`endif

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Serial command front end that sits directly upstream of the FSM core. It drives the FSM's a, b and opcode inputs from a UART line instead of from static pins.
- Receives 8N1 bytes and assembles two-byte command frames: a header carrying the opcode, then a packed operand byte.
- Presents each command on a valid/ready handshake with a one-entry holding register.
- Reports framing, header and overflow errors.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit period; must be >= 4.
- HDR_TAG, 5'b10100, required value of header byte bits [7:3].
- TIMEOUT_BITS, 32, inter-byte timeout in bit periods; used only with the optional feature.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ena  input  1  block enable; when low the receiver is held in IDLE and rx is ignored.
- rx  input  1  UART serial input; idle high; asynchronous to clock.
- cmd_ready  input  1  FSM accepts the command this cycle.
- cmd_valid  output  1  command held on cmd_* is valid.
- cmd_a  output  4  operand A (byte1[7:4]).
- cmd_b  output  4  operand B (byte1[3:0]).
- cmd_opcode  output  3  ALU opcode (header[2:0]).
- rx_busy  output  1  receiver is inside a byte frame (state != IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- hdr_err  output  1  one-cycle pulse: header byte [7:3] != HDR_TAG.
- overflow  output  1  sticky: a command completed while cmd_valid && !cmd_ready; cleared only by reset.

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-high, named reset.
- Reset values: all outputs 0; synchronizer flops and the previous-sample flop reset to 1; receiver in IDLE; parser in P_HDR.
- Synchronizer: rx passes through two flops to give rx_s. A start is a falling edge: previous rx_s = 1 and current rx_s = 0.
  - A line that is already low when reset is released is not a start. It must first be seen high.
- Receiver FSM:
  - IDLE: on a start edge with ena = 1, go to START and clear the cycle counter.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then re-sample. If rx_s = 1 it is a false start: return to IDLE with no error. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifting into the byte register. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If rx_s = 1, pulse byte_done (internal) for 1 cycle. If rx_s = 0, pulse frame_err and discard the byte. In both cases return to IDLE that same cycle, so a back-to-back start is detectable immediately.
  - If ena falls mid-frame, the receiver aborts to IDLE, the partial byte is discarded and no error is raised. Parser state is kept.
- Parser:
  - P_HDR: on byte_done, if byte[7:3] == HDR_TAG, latch byte[2:0] into a pending opcode and go to P_DATA. Otherwise pulse hdr_err and stay in P_HDR.
  - P_DATA: on byte_done, the command completes and the parser returns to P_HDR. The operand byte is never header-checked.
  - A frame_err in P_DATA sends the parser back to P_HDR, dropping the pending opcode.
- Output register and handshake:
  - Command complete with cmd_valid = 0, or with cmd_valid = 1 && cmd_ready = 1 in the same cycle: load cmd_opcode, cmd_a and cmd_b, and set cmd_valid on the next edge.
  - Command complete with cmd_valid = 1 && cmd_ready = 0: drop the new command, set overflow, leave cmd_* unchanged.
  - cmd_valid = 1 && cmd_ready = 1 with no completion: clear cmd_valid next edge.
  - cmd_* are stable while cmd_valid = 1. cmd_ready is ignored when cmd_valid = 0.
- Latency: cmd_valid rises 1 cycle after the byte_done of the operand byte. That is about 2 + (9.5 × CLKS_PER_BIT) cycles after the operand byte's start edge, with synchronizer delay included.
- A reset asserted mid-frame or mid-command clears everything asynchronously. No partial command survives.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- Defined:
  - A counter runs while the parser is in P_DATA and rx_busy = 0.
  - When it reaches TIMEOUT_BITS × CLKS_PER_BIT, the parser reverts to P_HDR and pulses an extra output, timeout_err, for 1 cycle.
  - The counter clears on any start edge and on entry to P_DATA.
- Not defined: no timeout_err port and no counter. The parser waits in P_DATA indefinitely.

Test Plan (CLKS_PER_BIT = 16, cmd_ready tied 1 unless stated):
- Send 0xA3, then 0x5C, back to back -> single 1-cycle cmd_valid with cmd_opcode = 3, cmd_a = 5, cmd_b = 12; no error pulses.
- Send 0x7F, then 0xA1, then 0x21 -> hdr_err pulses once after the first byte; then command opcode 1, a = 2, b = 1.
- cmd_ready = 0; send two full commands (A2/34, then A5/67) -> first command held on cmd_* (2/3/4); overflow = 1 after the second; raising cmd_ready drops cmd_valid and cmd_* still read 2/3/4.
- Send header 0xA4, then a byte with stop bit forced 0 -> frame_err pulse; no cmd_valid; a following valid A4/11 yields opcode 4, a = 1, b = 1.
- Glitch rx low for 4 cycles, then a reset pulse mid-byte of a header -> no byte_done and no error from the glitch; after reset all outputs 0; the next full command is received correctly.
- With UART_CMD_TIMEOUT_EN: send 0xA2, then idle 600 cycles -> timeout_err pulse at 512 idle cycles after the stop bit; a following 0x34 alone gives hdr_err and no command.
